vid_mem_arbiter: RTL and testbench
==================================

Name: vid_mem_arbiter

Overview:
- Shares the single video/main RAM port between the video controller's pixel and roller fetch path and the Z80 CPU memory cycle.
- Grants one access at a time, returns read data with a fixed, known latency, and stalls the CPU through a wait output while video holds the port.
- Video has priority. A starvation counter bounds CPU wait so the CPU cannot be locked out during active display.
- Sits between video_controller / CPU bus glue and the RAM wrapper.

Parameters:
- ADDR_W, 17, RAM byte address width (128 KB)
- RD_LAT, 2, clk_sys cycles from mem_addr presented to mem_rdata valid (1..4)
- MAX_CPU_WAIT, 12, clk_sys cycles a pending CPU request may be held off before it wins the next grant

Ports:
- clk_sys  in  1  64 MHz system clock
- reset_n  in  1  asynchronous, active-low reset
- vid_req  in  1  video read request, level, held until vid_valid
- vid_addr  in  ADDR_W  video read address, stable while vid_req
- vid_data  out  8  video read data
- vid_valid  out  1  one-cycle pulse, vid_data valid
- cpu_rd  in  1  CPU read request, level, held until cpu_ack
- cpu_wr  in  1  CPU write request, level, held until cpu_ack
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  CPU read data, held until the next CPU read completes
- cpu_ack  out  1  one-cycle pulse, CPU access complete
- cpu_wait  out  1  high while a CPU request is pending and not acked (drives Z80 WAIT)
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  8  RAM write data
- mem_we  out  1  RAM write strobe, one cycle
- mem_rdata  in  8  RAM read data, RD_LAT cycles after address

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; vid_valid, cpu_ack, mem_we=0; mem_addr, mem_wdata, vid_data, cpu_rdata=0; starve counter=0.
- cpu_wait is combinational: (cpu_rd|cpu_wr) & ~cpu_ack.
- cpu_rd and cpu_wr asserted together is illegal. The arbiter treats it as a write; the bench flags it as an assertion.
- FSM states: IDLE, VID_RD, CPU_RD, CPU_WR, DONE.
- Arbitration occurs in IDLE and in DONE, so back-to-back grants are allowed:
  - If the CPU is pending and starve >= MAX_CPU_WAIT: grant the CPU.
  - Else if vid_req: grant video.
  - Else if the CPU is pending: grant the CPU.
  - Else go to IDLE.
- Grant cycle: mem_addr is registered from the winner's address. A request that drops before grant is ignored.
- VID_RD / CPU_RD: a latency counter runs RD_LAT cycles.
  - On expiry, mem_rdata is captured into vid_data or cpu_rdata.
  - vid_valid or cpu_ack pulses for 1 cycle, then DONE.
  - Read occupancy = 1 + RD_LAT cycles. Request-to-valid = RD_LAT+1 clk_sys with no contention.
- CPU_WR: mem_we=1 and mem_wdata=cpu_wdata for exactly 1 cycle; cpu_ack pulses the following cycle (DONE).
- DONE: 1 cycle. Requesters must drop or re-present the request on the cycle after ack/valid. A request still high in DONE is treated as a new request.
- Starve counter:
  - Increments each cycle the CPU is pending and not being serviced; saturates at MAX_CPU_WAIT.
  - Clears on CPU grant or when the CPU request drops.
- Video is never lost. If the CPU wins by starvation, video waits one access (worst case 2+RD_LAT cycles extra). That fits inside the 32-clk_sys byte slot (8 pixels x 4 clk_sys) used by video_controller.
- Address and write data are sampled only at grant; changes after grant do not affect the access in progress.
- Reset asserted mid-access aborts immediately with no ack or valid. The RAM write is suppressed if reset lands on the mem_we cycle.

Decomposition:
- Shared package pcw_mem_pkg:
  - arb_state_t enum (IDLE, VID_RD, CPU_RD, CPU_WR, DONE)
  - PCW_ADDR_W=17
  - default RD_LAT and MAX_CPU_WAIT constants
- One natural sub-module: arb_starve_ctr (saturating counter, clear/inc/sat flag).
- Latency counter and FSM stay in the top.

Test Plan:
- Video-only: vid_req=1, vid_addr=17'h00100, RAM[100h]=8'hA5, RD_LAT=2 -> vid_valid exactly 3 cycles after req, vid_data=A5, cpu_wait=0.
- CPU write then read: cpu_wr addr 17'h1F000 data 8'h3C -> mem_we one cycle with addr 1F000/data 3C, cpu_ack next cycle. Then cpu_rd same addr -> cpu_rdata=3C, cpu_ack at cycle 3.
- Simultaneous vid_req and cpu_rd from IDLE -> video granted first; CPU ack follows the video access; cpu_wait high until ack.
- Starvation: vid_req held high continuously, cpu_rd asserted -> CPU granted no later than MAX_CPU_WAIT+RD_LAT+2 cycles (16); video resumes next; starve counter back to 0.
- Reset mid-read: reset_n pulled low during VID_RD -> no vid_valid, all outputs 0 asynchronously. After release with vid_req still high -> normal access completes.
- Back-to-back: vid_req and cpu_rd both re-asserted every ack, 100 cycles -> alternation never gives the CPU more than MAX_CPU_WAIT idle cycles; no cycle has both ack and valid.

Source files
------------

// File: rtl/vid_mem_arbiter_pkg.sv
// Shared definitions for the PCW video/CPU memory arbiter: arbiter states,
// address width and default timing constants.
package pcw_mem_pkg;

  localparam int PCW_ADDR_W         = 17;
  localparam int PCW_RD_LAT         = 2;
  localparam int PCW_MAX_CPU_WAIT   = 12;

  typedef enum logic [2:0] {
    IDLE,
    VID_RD,
    CPU_RD,
    CPU_WR,
    DONE
  } arb_state_t;

endpackage

// File: rtl/vid_mem_arbiter_if.sv
// Bundle of the video, CPU and RAM-side signals around the memory arbiter.
// master is the arbiter's view; slave is the view of the requesters plus RAM.
interface vid_mem_arbiter_if import pcw_mem_pkg::*; #(
  parameter int ADDR_W = PCW_ADDR_W
);

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [7:0]        vid_data;
  logic              vid_valid;

  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              cpu_ack;
  logic              cpu_wait;

  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic [7:0]        mem_rdata;

  modport master (
    input  vid_req, vid_addr, cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_rdata,
    output vid_data, vid_valid, cpu_rdata, cpu_ack, cpu_wait,
           mem_addr, mem_wdata, mem_we
  );

  modport slave (
    output vid_req, vid_addr, cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_rdata,
    input  vid_data, vid_valid, cpu_rdata, cpu_ack, cpu_wait,
           mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/vid_mem_arbiter_starve_ctr.sv
// Saturating count of cycles a pending CPU request has been held off;
// sat tells the arbiter the CPU must win the next grant.
module arb_starve_ctr import pcw_mem_pkg::*; #(
  parameter int MAX = PCW_MAX_CPU_WAIT
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic sat
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + 1'b1;
    end
  end

  assign sat = (count >= W'(MAX));

endmodule

// File: rtl/vid_mem_arbiter.sv
// Single-port RAM arbiter between the video fetch path and the Z80 bus.
// Video has priority; a starvation counter forces a CPU grant when it saturates.
module vid_mem_arbiter import pcw_mem_pkg::*; #(
  parameter int ADDR_W       = PCW_ADDR_W,
  parameter int RD_LAT       = PCW_RD_LAT,
  parameter int MAX_CPU_WAIT = PCW_MAX_CPU_WAIT
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  vid_mem_arbiter_if.master bus
);

  arb_state_t state, state_next;

  logic [2:0]        lat_cnt;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              mem_we_q;
  logic [7:0]        vid_data_q;
  logic              vid_valid_q;
  logic [7:0]        cpu_rdata_q;
  logic              cpu_ack_q;

  logic cpu_pend;
  logic starve_sat;
  logic grant_vid;
  logic grant_cpu;
  logic rd_done;

  assign cpu_pend = bus.cpu_rd | bus.cpu_wr;

  arb_starve_ctr #(
    .MAX (MAX_CPU_WAIT)
  ) u_starve (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .clr     (!cpu_pend || grant_cpu),
    .inc     (cpu_pend && (state != CPU_RD) && (state != CPU_WR)),
    .sat     (starve_sat)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // IDLE and DONE are both grant points, so a new access can start straight
  // out of DONE; a CPU request with rd and wr together is served as a write.
  always_comb begin
    state_next = state;
    grant_vid  = 1'b0;
    grant_cpu  = 1'b0;
    rd_done    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (cpu_pend && starve_sat) begin
          grant_cpu = 1'b1;
        end else if (bus.vid_req) begin
          grant_vid = 1'b1;
        end else if (cpu_pend) begin
          grant_cpu = 1'b1;
        end
        if (grant_vid) begin
          state_next = VID_RD;
        end else if (grant_cpu) begin
          state_next = bus.cpu_wr ? CPU_WR : CPU_RD;
        end else begin
          state_next = IDLE;
        end
      end
      VID_RD, CPU_RD: begin
        if (lat_cnt == 3'd0) begin
          rd_done    = 1'b1;
          state_next = DONE;
        end
      end
      CPU_WR:  state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Address and write data are captured only at grant; read data is taken
  // from the RAM on the last latency cycle and the pulse lands in DONE.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      lat_cnt     <= 3'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
      mem_we_q    <= 1'b0;
      vid_data_q  <= 8'd0;
      vid_valid_q <= 1'b0;
      cpu_rdata_q <= 8'd0;
      cpu_ack_q   <= 1'b0;
    end else begin
      mem_we_q    <= grant_cpu && bus.cpu_wr;
      vid_valid_q <= rd_done && (state == VID_RD);
      cpu_ack_q   <= (rd_done && (state == CPU_RD)) || (state == CPU_WR);
      if (grant_vid) begin
        mem_addr_q <= bus.vid_addr;
      end else if (grant_cpu) begin
        mem_addr_q <= bus.cpu_addr;
      end
      if (grant_cpu && bus.cpu_wr) begin
        mem_wdata_q <= bus.cpu_wdata;
      end
      if (grant_vid || grant_cpu) begin
        lat_cnt <= 3'(RD_LAT - 1);
      end else if ((state == VID_RD || state == CPU_RD) && lat_cnt != 3'd0) begin
        lat_cnt <= lat_cnt - 3'd1;
      end
      if (rd_done && (state == VID_RD)) begin
        vid_data_q <= bus.mem_rdata;
      end
      if (rd_done && (state == CPU_RD)) begin
        cpu_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.vid_data  = vid_data_q;
  assign bus.vid_valid = vid_valid_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_wait  = cpu_pend & ~cpu_ack_q;

endmodule

// File: tb/tb_vid_mem_arbiter.sv
// Self-checking bench for vid_mem_arbiter: transaction-level occupancy model,
// per-cycle compare process, directed scenarios and randomized traffic.
module tb_vid_mem_arbiter;
  import pcw_mem_pkg::*;

  localparam int ADDR_W   = 17;
  localparam int RD_LAT   = 2;
  localparam int MAX_WAIT = 12;
  localparam int ACK_BOUND = MAX_WAIT + 2 * RD_LAT + 1;
  localparam int MEM_SIZE = 1 << ADDR_W;
  localparam int O_VID = 0, O_RD = 1, O_WR = 2;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  vid_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  vid_mem_arbiter #(
    .ADDR_W       (ADDR_W),
    .RD_LAT       (RD_LAT),
    .MAX_CPU_WAIT (MAX_WAIT)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] init_byte(input int i);
    if (i == 32'h100) return 8'hA5;
    return 8'(i * 37 + (i >> 7));
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Counts clock edges until vid_valid (sel 0) or cpu_ack (sel 1); -1 on timeout.
  task automatic wait_for(input int sel, input int limit, output int edges);
    logic hit;
    edges = 0;
    hit   = 1'b0;
    while (!hit && edges < limit) begin
      tick();
      edges++;
      hit = (sel == 0) ? bus.vid_valid : bus.cpu_ack;
    end
    if (!hit) edges = -1;
  endtask

  // RAM with one registered read stage: data for the address seen at an edge
  // is on mem_rdata during the following cycle.
  logic [7:0] ram [MEM_SIZE];
  initial begin
    logic [7:0] rd;
    for (int i = 0; i < MEM_SIZE; i++) ram[i] = init_byte(i);
    bus.mem_rdata = 8'd0;
    forever begin
      @(posedge clk_sys);
      rd = ram[bus.mem_addr];
      if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
      bus.mem_rdata <= rd;
    end
  end

  // Reference model: the port is either free (a grant point) or busy for a
  // fixed number of cycles; completion raises the pulse for the next cycle.
  logic [7:0]        shadow [MEM_SIZE];
  int                m_busy = 0, m_owner = 0, m_starve = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [7:0]        m_wdata = 8'd0;
  logic              e_valid = 1'b0, e_ack = 1'b0, e_we = 1'b0;
  logic [ADDR_W-1:0] e_mem_addr = '0;
  logic [7:0]        e_wdata = 8'd0, e_vid_data = 8'd0, e_cpu_rdata = 8'd0;

  initial begin
    logic pend, in_service, take_cpu;
    for (int i = 0; i < MEM_SIZE; i++) shadow[i] = init_byte(i);
    forever begin
      @(posedge clk_sys or negedge reset_n);
      if (!reset_n) begin
        m_busy = 0; m_starve = 0;
        e_valid = 1'b0; e_ack = 1'b0; e_we = 1'b0;
        e_mem_addr = '0; e_wdata = 8'd0; e_vid_data = 8'd0; e_cpu_rdata = 8'd0;
      end else begin
        pend       = bus.cpu_rd | bus.cpu_wr;
        in_service = (m_busy > 0) && (m_owner != O_VID);
        take_cpu   = 1'b0;
        e_valid = 1'b0; e_ack = 1'b0; e_we = 1'b0;
        if (m_busy > 0) begin
          m_busy--;
          if (m_busy == 0) begin
            case (m_owner)
              O_VID:   begin e_vid_data = shadow[m_addr]; e_valid = 1'b1; end
              O_RD:    begin e_cpu_rdata = shadow[m_addr]; e_ack = 1'b1; end
              default: begin shadow[m_addr] = m_wdata; e_ack = 1'b1; end
            endcase
          end
        end else begin
          take_cpu = pend && (m_starve >= MAX_WAIT || !bus.vid_req);
          if (take_cpu) begin
            m_owner    = bus.cpu_wr ? O_WR : O_RD;
            m_addr     = bus.cpu_addr;
            m_wdata    = bus.cpu_wdata;
            m_busy     = bus.cpu_wr ? 1 : RD_LAT;
            e_mem_addr = m_addr;
            if (bus.cpu_wr) begin
              e_we    = 1'b1;
              e_wdata = m_wdata;
            end
          end else if (bus.vid_req) begin
            m_owner    = O_VID;
            m_addr     = bus.vid_addr;
            m_busy     = RD_LAT;
            e_mem_addr = m_addr;
          end
        end
        if (!pend || take_cpu) m_starve = 0;
        else if (!in_service && m_starve < MAX_WAIT) m_starve++;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    int cpu_len;
    logic pend;
    cpu_len = 0;
    forever begin
      @(negedge clk_sys);
      pend = bus.cpu_rd | bus.cpu_wr;
      check_output("vid_valid", 32'(bus.vid_valid), 32'(e_valid));
      check_output("cpu_ack", 32'(bus.cpu_ack), 32'(e_ack));
      check_output("mem_we", 32'(bus.mem_we), 32'(e_we));
      check_output("cpu_wait", 32'(bus.cpu_wait), 32'(pend & ~e_ack));
      check_output("mem_addr", 32'(bus.mem_addr), 32'(e_mem_addr));
      check_output("vid_data", 32'(bus.vid_data), 32'(e_vid_data));
      check_output("cpu_rdata", 32'(bus.cpu_rdata), 32'(e_cpu_rdata));
      check_output("ack_and_valid", 32'(bus.cpu_ack & bus.vid_valid), 32'd0);
      if (e_we) check_output("mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
      if (!reset_n) begin
        cpu_len = 0;
      end else if (bus.cpu_ack) begin
        check_output("cpu_wait_bound", 32'(cpu_len > ACK_BOUND), 32'd0);
        cpu_len = pend ? 1 : 0;
      end else if (pend) begin
        cpu_len++;
      end
    end
  end

  always @(posedge clk_sys) begin
    assert (!(reset_n && bus.cpu_rd && bus.cpu_wr))
      else $error("[TB] illegal: cpu_rd and cpu_wr asserted together");
  end

  task automatic apply_stimulus(input int cycles, input int vid_pct, input int cpu_pct, input bit allow_wr);
    int r;
    for (int c = 0; c < cycles; c++) begin
      if (!bus.vid_req || bus.vid_valid) begin
        bus.vid_req  = ($urandom_range(0, 99) < vid_pct);
        bus.vid_addr = 17'h1F000 + 17'($urandom_range(0, 63));
      end
      if (!(bus.cpu_rd || bus.cpu_wr) || bus.cpu_ack) begin
        r = $urandom_range(0, 99);
        bus.cpu_rd    = 1'b0;
        bus.cpu_wr    = 1'b0;
        bus.cpu_addr  = 17'h1F000 + 17'($urandom_range(0, 63));
        bus.cpu_wdata = 8'($urandom);
        if (r < cpu_pct) begin
          if (allow_wr && $urandom_range(0, 1) == 1) bus.cpu_wr = 1'b1;
          else bus.cpu_rd = 1'b1;
        end
      end
      tick();
    end
  endtask

  initial begin
    int n;
    bus.vid_req = 1'b0; bus.vid_addr = '0;
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = 8'd0;
    reset_n = 1'b0;
    repeat (3) tick();
    check_output("rst_vid_valid", 32'(bus.vid_valid), 32'd0);
    check_output("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
    check_output("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check_output("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check_output("rst_cpu_wait", 32'(bus.cpu_wait), 32'd0);
    reset_n = 1'b1;

    $display("[TB] video-only read");
    bus.vid_req = 1'b1; bus.vid_addr = 17'h00100;
    wait_for(0, 10, n);
    check_output("vid_latency", 32'(n), 32'd3);
    check_output("vid_data_a5", 32'(bus.vid_data), 32'hA5);
    check_output("vid_cpu_wait", 32'(bus.cpu_wait), 32'd0);
    bus.vid_req = 1'b0;
    tick();

    $display("[TB] cpu write then read");
    bus.cpu_wr = 1'b1; bus.cpu_addr = 17'h1F000; bus.cpu_wdata = 8'h3C;
    tick();
    check_output("wr_mem_we", 32'(bus.mem_we), 32'd1);
    check_output("wr_mem_addr", 32'(bus.mem_addr), 32'h1F000);
    check_output("wr_mem_wdata", 32'(bus.mem_wdata), 32'h3C);
    check_output("wr_no_early_ack", 32'(bus.cpu_ack), 32'd0);
    tick();
    check_output("wr_ack", 32'(bus.cpu_ack), 32'd1);
    check_output("wr_we_one_cycle", 32'(bus.mem_we), 32'd0);
    bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b1;
    wait_for(1, 10, n);
    check_output("rd_latency", 32'(n), 32'd3);
    check_output("rd_data_3c", 32'(bus.cpu_rdata), 32'h3C);
    bus.cpu_rd = 1'b0;
    tick();

    $display("[TB] simultaneous video and cpu");
    bus.vid_req = 1'b1; bus.vid_addr = 17'h00100; bus.cpu_rd = 1'b1; bus.cpu_addr = 17'h1F000;
    wait_for(0, 10, n);
    check_output("sim_vid_first", 32'(n), 32'd3);
    check_output("sim_cpu_wait", 32'(bus.cpu_wait), 32'd1);
    bus.vid_req = 1'b0;
    wait_for(1, 10, n);
    check_output("sim_cpu_after", 32'(n), 32'd3);
    bus.cpu_rd = 1'b0;
    repeat (2) tick();

    $display("[TB] starvation");
    bus.vid_req = 1'b1; bus.vid_addr = 17'h00100; bus.cpu_rd = 1'b1; bus.cpu_addr = 17'h1F000;
    wait_for(1, 30, n);
    check_output("starve_ack", 32'(n), 32'd15);
    check_output("starve_rdata", 32'(bus.cpu_rdata), 32'h3C);
    bus.cpu_rd = 1'b0;
    wait_for(0, 10, n);
    check_output("starve_vid_resume", 32'(n), 32'd3);
    check_output("starve_vid_data", 32'(bus.vid_data), 32'hA5);
    bus.cpu_rd = 1'b1;
    wait_for(1, 30, n);
    check_output("starve_cleared", 32'(n), 32'd15);
    bus.cpu_rd = 1'b0; bus.vid_req = 1'b0;
    repeat (4) tick();

    $display("[TB] reset during video read");
    bus.vid_req = 1'b1; bus.vid_addr = 17'h1F000;
    tick();
    #2 reset_n = 1'b0;
    #1;
    check_output("arst_vid_data", 32'(bus.vid_data), 32'd0);
    check_output("arst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
    check_output("arst_mem_addr", 32'(bus.mem_addr), 32'd0);
    repeat (2) tick();
    check_output("arst_no_valid", 32'(bus.vid_valid), 32'd0);
    reset_n = 1'b1;
    wait_for(0, 10, n);
    check_output("arst_recover", 32'(n), 32'd3);
    check_output("arst_recover_data", 32'(bus.vid_data), 32'h3C);
    bus.vid_req = 1'b0;
    repeat (2) tick();

    $display("[TB] back-to-back traffic");
    apply_stimulus(100, 100, 100, 1'b0);
    $display("[TB] random traffic");
    apply_stimulus(600, 70, 60, 1'b1);

    bus.vid_req = 1'b0; bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
    repeat (8) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
